heuristic_selector_seq: RTL

- Sequential, parametrised successor to the 3-candidate combinational selector in the WalkSAT flip path.
- Accepts NSAT break values with per-candidate valid bits in one valid/ready transfer.
- Chooses the variable to flip: valid zero-break candidate first, else random walk or greedy minimum.
- Scans one candidate per clock, so NSAT is unbounded, and returns the result over a registered valid/ready output.

---
 rtl/heuristic_selector_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/heuristic_selector_seq.sv
// Sequential WalkSAT flip-variable selector: one candidate evaluated per clock.
// Optional macro HS_EARLY_EXIT_EN ends the ZERO/WALK scan as soon as a pick is made.
module heuristic_selector_seq #(
  parameter int          NSAT                     = 3,
  parameter int          MAX_CLAUSES_PER_VARIABLE = 20,
  parameter logic [31:0] P                        = 32'h6E147AE0,
  parameter int          SELW                     = (NSAT > 1) ? $clog2(NSAT) : 1,
  localparam int         MCB = (MAX_CLAUSES_PER_VARIABLE > 1) ? $clog2(MAX_CLAUSES_PER_VARIABLE) : 1,
  localparam int         CW  = $clog2(NSAT + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [NSAT*MCB-1:0] break_values_i,
  input  logic [NSAT-1:0]     break_values_valid_i,
  input  logic [31:0]         random_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [SELW-1:0]     select_o,
  output logic                random_selection_o,
  output logic                no_candidate_o
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
  typedef enum logic [1:0] {M_NONE, M_ZERO, M_WALK, M_GREEDY} mode_t;

  state_t          state_q, state_d;
  mode_t           mode_q, mode_d, mode_acc;
  logic [MCB-1:0]  vals_q [NSAT];
  logic [MCB-1:0]  vals_d [NSAT];
  logic [MCB-1:0]  bv_in  [NSAT];
  logic [NSAT-1:0] vmask_q, vmask_d;
  logic [CW-1:0]   k_q, k_d, cnt_q, cnt_d, nv, nv_div;
  logic [SELW-1:0] idx_q, idx_d, sel_q, sel_d;
  logic [MCB-1:0]  min_q, min_d;
  logic            scan_end_q, scan_end_d, found_q, found_d;
  logic            rsel_q, rsel_d, nocand_q, nocand_d;
  logic            has_zero, pick, last;
  logic [15:0]     k_full;
  logic            cur_v;
  logic [MCB-1:0]  cur_b;

  for (genvar gi = 0; gi < NSAT; gi++) begin : g_unpack
    assign bv_in[gi] = break_values_i[gi*MCB +: MCB];
  end

  // Request classification, only meaningful on the accepting edge.
  always_comb begin
    nv       = '0;
    has_zero = 1'b0;
    for (int i = 0; i < NSAT; i++) begin
      if (break_values_valid_i[i]) begin
        nv = nv + CW'(1);
        if (bv_in[i] == '0) has_zero = 1'b1;
      end
    end
    nv_div = (nv == '0) ? CW'(1) : nv;
    k_full = random_i[15:0] % 16'(nv_div);
    if (nv == '0)                             mode_acc = M_NONE;
    else if (has_zero)                        mode_acc = M_ZERO;
    else if (random_i > P && nv >= CW'(2))    mode_acc = M_WALK;
    else                                      mode_acc = M_GREEDY;
  end

  assign cur_v = vmask_q[idx_q];
  assign cur_b = vals_q[idx_q];
  assign last  = (idx_q == SELW'(NSAT - 1));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    vals_d     = vals_q;
    vmask_d    = vmask_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    min_d      = min_q;
    scan_end_d = scan_end_q;
    found_d    = found_q;
    rsel_d     = rsel_q;
    nocand_d   = nocand_q;
    pick       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          vals_d     = bv_in;
          vmask_d    = break_values_valid_i;
          mode_d     = mode_acc;
          k_d        = CW'(k_full);
          cnt_d      = '0;
          idx_d      = '0;
          sel_d      = '0;
          min_d      = '0;
          scan_end_d = 1'b0;
          found_d    = 1'b0;
          rsel_d     = (mode_acc == M_WALK);
          nocand_d   = (mode_acc == M_NONE);
          state_d    = (mode_acc == M_NONE) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        // The extra cycle after the last evaluation registers the result before DONE.
        if (scan_end_q) begin
          state_d = S_DONE;
        end else begin
          case (mode_q)
            M_ZERO: pick = cur_v && !found_q && (cur_b == '0);
            M_WALK: begin
              pick = cur_v && !found_q && (cnt_q == k_q);
              if (cur_v) cnt_d = cnt_q + CW'(1);
            end
            default: pick = cur_v && (!found_q || cur_b < min_q);
          endcase
          if (pick) begin
            sel_d   = idx_q;
            min_d   = cur_b;
            found_d = 1'b1;
          end
`ifdef HS_EARLY_EXIT_EN
          if (last || (pick && mode_q != M_GREEDY)) scan_end_d = 1'b1;
          else                                      idx_d = idx_q + SELW'(1);
`else
          if (last) scan_end_d = 1'b1;
          else      idx_d = idx_q + SELW'(1);
`endif
        end
      end
      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= M_NONE;
      for (int i = 0; i < NSAT; i++) vals_q[i] <= '0;
      vmask_q    <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      min_q      <= '0;
      scan_end_q <= 1'b0;
      found_q    <= 1'b0;
      rsel_q     <= 1'b0;
      nocand_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      vals_q     <= vals_d;
      vmask_q    <= vmask_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      min_q      <= min_d;
      scan_end_q <= scan_end_d;
      found_q    <= found_d;
      rsel_q     <= rsel_d;
      nocand_q   <= nocand_d;
    end
  end

  assign in_ready_o         = (state_q == S_IDLE);
  assign out_valid_o        = (state_q == S_DONE);
  assign select_o           = sel_q;
  assign random_selection_o = rsel_q;
  assign no_candidate_o     = nocand_q;

endmodule
